// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU and long-latency results into one registered RF write port
// Optional decode-stage forwarding outputs are built when WB_ARBITER_FWD_EN is defined.
module wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alu_valid,
   input  logic [4:0]    alu_rd,
   input  logic [31:0]   alu_data,
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic [4:0]    mem_rd,
   input  logic [31:0]   mem_data,
   output logic          rf_wen,
   output logic [4:0]    rf_rd,
   output logic [31:0]   rf_wdata,
   input  logic [4:0]    pend_rs1,
   input  logic [4:0]    pend_rs2,
   output logic          pend_hit,
`ifdef WB_ARBITER_FWD_EN
   output logic          fwd_hit1,
   output logic [31:0]   fwd_data1,
   output logic          fwd_hit2,
   output logic [31:0]   fwd_data2,
`endif
   output logic [CW-1:0] fifo_count
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [4:0]    q_rd   [DEPTH];
   logic [31:0]   q_data [DEPTH];

   logic alu_req;
   logic mem_acc;
   logic mem_live;
   logic fifo_empty;
   logic pop;
   logic bypass;
   logic push;

   assign alu_req    = alu_valid && (alu_rd != 5'd0);
   // Ready looks only at the registered count, so a same-cycle pop never frees a full FIFO.
   assign mem_ready  = (fifo_count < CW'(DEPTH));
   assign mem_acc    = mem_valid && mem_ready;
   assign mem_live   = mem_acc && (mem_rd != 5'd0);
   assign fifo_empty = (fifo_count == '0);
   assign pop        = !alu_req && !fifo_empty;
   assign bypass     = !alu_req && fifo_empty && mem_live;
   assign push       = mem_live && !bypass;

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_wen     <= 1'b0;
         rf_rd      <= 5'd0;
         rf_wdata   <= 32'd0;
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
      end else begin
         if (alu_req) begin
            rf_wen   <= 1'b1;
            rf_rd    <= alu_rd;
            rf_wdata <= alu_data;
         end else if (pop) begin
            rf_wen   <= 1'b1;
            rf_rd    <= q_rd[rptr];
            rf_wdata <= q_data[rptr];
         end else if (bypass) begin
            rf_wen   <= 1'b1;
            rf_rd    <= mem_rd;
            rf_wdata <= mem_data;
         end else begin
            rf_wen   <= 1'b0;
         end
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: entries are only visible through the count.
   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wptr]   <= mem_rd;
         q_data[wptr] <= mem_data;
      end
   end

   logic [PW-1:0] offs;

   always_comb begin
      pend_hit = 1'b0;
      offs     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = PW'(i) - rptr;
         if ((CW'(offs) < fifo_count) && (q_rd[i] != 5'd0) &&
             ((q_rd[i] == pend_rs1) || (q_rd[i] == pend_rs2)))
            pend_hit = 1'b1;
      end
   end

`ifdef WB_ARBITER_FWD_EN
   assign fwd_hit1  = rf_wen && (rf_rd != 5'd0) && (rf_rd == pend_rs1);
   assign fwd_hit2  = rf_wen && (rf_rd != 5'd0) && (rf_rd == pend_rs2);
   assign fwd_data1 = rf_wdata;
   assign fwd_data2 = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        rf_wen;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic [4:0]  pend_rs1;
   logic [4:0]  pend_rs2;
   logic        pend_hit;
   logic [2:0]  fifo_count;
`ifdef WB_ARBITER_FWD_EN
   logic        fwd_hit1;
   logic [31:0] fwd_data1;
   logic        fwd_hit2;
   logic [31:0] fwd_data2;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .pend_rs1(pend_rs1), .pend_rs2(pend_rs2), .pend_hit(pend_hit),
`ifdef WB_ARBITER_FWD_EN
      .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
`endif
      .fifo_count(fifo_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle(); pend_rs1 = 5'd0; pend_rs2 = 5'd0;
      tick(); tick();
      rst = 1'b0; #1;
      n_checks++; if (rf_wen !== 1'b0) $display("FAIL reset_wen: got %0h want 0", rf_wen); else n_pass++;
      n_checks++; if (rf_rd !== 5'd0) $display("FAIL reset_rd: got %0d want 0", rf_rd); else n_pass++;
      n_checks++; if (rf_wdata !== 32'd0) $display("FAIL reset_wdata: got %0h want 0", rf_wdata); else n_pass++;
      n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else n_pass++;
      n_checks++; if (mem_ready !== 1'b1) $display("FAIL reset_ready: got %0h want 1", mem_ready); else n_pass++;
      n_checks++; if (pend_hit !== 1'b0) $display("FAIL reset_pend: got %0h want 0", pend_hit); else n_pass++;
   endtask

   task automatic test_alu();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      tick(); idle();
      n_checks++; if (rf_wen !== 1'b1) $display("FAIL alu_wen: got %0h want 1", rf_wen); else n_pass++;
      n_checks++; if (rf_rd !== 5'd5) $display("FAIL alu_rd: got %0d want 5", rf_rd); else n_pass++;
      n_checks++; if (rf_wdata !== 32'hDEADBEEF) $display("FAIL alu_data: got %0h want deadbeef", rf_wdata); else n_pass++;
      tick();
      n_checks++; if (rf_wen !== 1'b0) $display("FAIL alu_wen_off: got %0h want 0", rf_wen); else n_pass++;
      n_checks++; if (rf_wdata !== 32'hDEADBEEF) $display("FAIL alu_hold: got %0h want deadbeef", rf_wdata); else n_pass++;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h12345678;
      tick(); idle();
      n_checks++; if (rf_wen !== 1'b0) $display("FAIL alu_rd0: got %0h want 0", rf_wen); else n_pass++;
   endtask

   task automatic test_same_cycle();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
      mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h22;
      tick(); idle();
      n_checks++; if (rf_rd !== 5'd3 || rf_wdata !== 32'h11 || rf_wen !== 1'b1)
         $display("FAIL same_first: got rd=%0d data=%0h want rd=3 data=11", rf_rd, rf_wdata); else n_pass++;
      n_checks++; if (fifo_count !== 3'd1) $display("FAIL same_count1: got %0d want 1", fifo_count); else n_pass++;
      tick();
      n_checks++; if (rf_rd !== 5'd4 || rf_wdata !== 32'h22 || rf_wen !== 1'b1)
         $display("FAIL same_second: got rd=%0d data=%0h want rd=4 data=22", rf_rd, rf_wdata); else n_pass++;
      n_checks++; if (fifo_count !== 3'd0) $display("FAIL same_count0: got %0d want 0", fifo_count); else n_pass++;
      mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
      tick(); idle();
      n_checks++; if (rf_rd !== 5'd6 || rf_wen !== 1'b1 || fifo_count !== 3'd0)
         $display("FAIL bypass: got rd=%0d wen=%0h cnt=%0d want rd=6 wen=1 cnt=0", rf_rd, rf_wen, fifo_count); else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [4:0] k;
      k = 5'd1;
      for (int i = 0; i < 6; i++) begin
         alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'(i);
         mem_valid = 1'b1; mem_rd = k; mem_data = 32'h100 + 32'(k);
         #1;
         n_checks++; if (mem_ready !== (i < 4)) $display("FAIL full_ready%0d: got %0h want %0h", i, mem_ready, (i < 4)); else n_pass++;
         tick();
         if (i < 4) k = k + 5'd1;
         n_checks++; if (rf_rd !== 5'(10 + i)) $display("FAIL full_alu%0d: got %0d want %0d", i, rf_rd, 10 + i); else n_pass++;
      end
      n_checks++; if (fifo_count !== 3'd4) $display("FAIL full_count: got %0d want 4", fifo_count); else n_pass++;
      alu_valid = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h105;
      tick();
      n_checks++; if (rf_rd !== 5'd1 || fifo_count !== 3'd3) $display("FAIL drain1: got rd=%0d cnt=%0d want rd=1 cnt=3", rf_rd, fifo_count); else n_pass++;
      n_checks++; if (mem_ready !== 1'b1) $display("FAIL drain_ready: got %0h want 1", mem_ready); else n_pass++;
      tick(); idle();
      n_checks++; if (rf_rd !== 5'd2 || fifo_count !== 3'd3) $display("FAIL drain2: got rd=%0d cnt=%0d want rd=2 cnt=3", rf_rd, fifo_count); else n_pass++;
      tick();
      n_checks++; if (rf_rd !== 5'd3 || rf_wdata !== 32'h103) $display("FAIL drain3: got rd=%0d data=%0h want rd=3 data=103", rf_rd, rf_wdata); else n_pass++;
      tick();
      n_checks++; if (rf_rd !== 5'd4 || fifo_count !== 3'd1) $display("FAIL drain4: got rd=%0d cnt=%0d want rd=4 cnt=1", rf_rd, fifo_count); else n_pass++;
      tick();
      n_checks++; if (rf_rd !== 5'd5 || rf_wdata !== 32'h105 || rf_wen !== 1'b1)
         $display("FAIL drain5: got rd=%0d data=%0h want rd=5 data=105", rf_rd, rf_wdata); else n_pass++;
      n_checks++; if (fifo_count !== 3'd0) $display("FAIL drain_count: got %0d want 0", fifo_count); else n_pass++;
      tick();
      n_checks++; if (rf_wen !== 1'b0) $display("FAIL drain_idle: got %0h want 0", rf_wen); else n_pass++;
   endtask

   task automatic test_pend_hit();
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
      tick(); idle();
      pend_rs1 = 5'd7; #1;
      n_checks++; if (pend_hit !== 1'b1) $display("FAIL pend_rs1: got %0h want 1", pend_hit); else n_pass++;
      pend_rs1 = 5'd8; #1;
      n_checks++; if (pend_hit !== 1'b0) $display("FAIL pend_miss: got %0h want 0", pend_hit); else n_pass++;
      pend_rs2 = 5'd7; #1;
      n_checks++; if (pend_hit !== 1'b1) $display("FAIL pend_rs2: got %0h want 1", pend_hit); else n_pass++;
      pend_rs1 = 5'd0; pend_rs2 = 5'd0;
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBAD; #1;
      n_checks++; if (pend_hit !== 1'b0) $display("FAIL pend_zero: got %0h want 0", pend_hit); else n_pass++;
      tick();
      n_checks++; if (rf_rd !== 5'd7 || rf_wen !== 1'b1 || fifo_count !== 3'd0)
         $display("FAIL rd0_pop: got rd=%0d wen=%0h cnt=%0d want rd=7 wen=1 cnt=0", rf_rd, rf_wen, fifo_count); else n_pass++;
      tick(); idle();
      n_checks++; if (rf_wen !== 1'b0 || fifo_count !== 3'd0)
         $display("FAIL rd0_drop: got wen=%0h cnt=%0d want wen=0 cnt=0", rf_wen, fifo_count); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      int bad;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'(i);
         mem_valid = 1'b1; mem_rd = 5'(11 + i); mem_data = 32'h200 + 32'(i);
         tick();
      end
      idle();
      n_checks++; if (fifo_count !== 3'd3) $display("FAIL mid_fill: got %0d want 3", fifo_count); else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (fifo_count !== 3'd0 || rf_wen !== 1'b0)
         $display("FAIL mid_reset: got cnt=%0d wen=%0h want cnt=0 wen=0", fifo_count, rf_wen); else n_pass++;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rf_wen !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) $display("FAIL mid_nowrite: got %0d writes want 0", bad); else n_pass++;
   endtask

`ifdef WB_ARBITER_FWD_EN
   task automatic test_fwd();
      pend_rs1 = 5'd0; pend_rs2 = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE;
      tick(); idle();
      pend_rs2 = 5'd9; #1;
      n_checks++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'hCAFE)
         $display("FAIL fwd_hit2: got hit=%0h data=%0h want hit=1 data=cafe", fwd_hit2, fwd_data2); else n_pass++;
      n_checks++; if (fwd_hit1 !== 1'b0) $display("FAIL fwd_hit1: got %0h want 0", fwd_hit1); else n_pass++;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBEEF; pend_rs2 = 5'd0;
      tick(); idle();
      n_checks++; if (fwd_hit2 !== 1'b0) $display("FAIL fwd_rd0: got %0h want 0", fwd_hit2); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_same_cycle();
      test_back_to_back();
      test_pend_hit();
      test_reset_mid();
`ifdef WB_ARBITER_FWD_EN
      test_fwd();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sitting directly upstream of the register file's single write port. It merges single-cycle ALU results with long-latency results (loads, multiply/divide) into one registered write stream of `rf_wen`/`rf_rd`/`rf_wdata`. Long-latency results that lose arbitration are held in a small FIFO. The block also reports pending-destination hazards to the issue stage.

## Interface
- `DEPTH`, default 4: FIFO entries for long-latency results; power of two, ≥ 2.
- `CW`, default `$clog2(DEPTH)+1`: width of the occupancy count.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `alu_valid` in 1: ALU result present this cycle; has no backpressure.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `mem_valid` in 1: long-latency result offered.
- `mem_ready` out 1: arbiter can accept a long-latency result.
- `mem_rd` in 5: long-latency destination register.
- `mem_data` in 32: long-latency result.
- `rf_wen` out 1: register-file write enable; registered.
- `rf_rd` out 5: register-file write address; registered.
- `rf_wdata` out 32: register-file write data; registered.
- `pend_rs1` in 5, `pend_rs2` in 5: issue-stage source registers to check.
- `pend_hit` out 1: a queued FIFO entry targets `pend_rs1` or `pend_rs2`; combinational.
- `fifo_count` out `CW`: current FIFO occupancy; registered.

## Operation
- Effective ALU request: `alu_valid && alu_rd != 0`. An ALU result with `rd == 0` is discarded.
- Long-latency handshake: `mem_valid && mem_ready`.
  - `mem_ready = (fifo_count < DEPTH)`, computed from the registered count only. A pop in the same cycle does not free a slot when the FIFO is full.
  - An accepted entry with `mem_rd == 0` is acknowledged and discarded. It is never pushed and never written.
- Fixed-priority selection each cycle; the winner is registered onto `rf_*`:
  1. Effective ALU request.
  2. Else FIFO head, if not empty; the head is popped.
  3. Else accepted long-latency result, when the FIFO is empty; it bypasses the FIFO.
  4. Else `rf_wen` is 0 next cycle, while `rf_rd` and `rf_wdata` hold their previous values.
- An accepted long-latency result that is not written via path 3 is pushed at the tail.
  - Simultaneous push and pop are allowed; the count is unchanged.
- Long-latency results always write in acceptance order; there is no reordering within the FIFO.
  - ALU results may overtake queued long-latency results. The issue stage must use `pend_hit` to stall any instruction that reads or writes a queued rd.
- `pend_hit` is 1 iff some valid FIFO entry has `rd != 0` and `rd == pend_rs1` or `rd == pend_rs2`.
- Continuous ALU traffic may starve the FIFO. This is intended; the issue stage throttles on `fifo_count`.
- FIFO uses read/write pointers of width `$clog2(DEPTH)` that wrap modulo `DEPTH`. Occupancy is tracked in the `fifo_count` register.

## Timing
- Reset values: `rf_wen=0`, `rf_rd=0`, `rf_wdata=0`, `fifo_count=0`, both pointers 0.
  - After reset, `mem_ready=1` and `pend_hit=0`.
- Reset mid-operation discards all queued entries; no write is issued for them.
- Latency:
  - ALU result: 1 cycle (cycle N input → `rf_wen` in cycle N+1).
  - Long-latency result, bypass path: 1 cycle.
  - Long-latency result, queued: 1 cycle after it becomes head with no ALU request.
- The register file captures the write at the edge ending cycle N+1. Its combinational read therefore returns the old value during cycle N+1.
- `mem_ready` and `pend_hit` are combinational from registers and `pend_rs*`. There is no combinational path from `mem_valid` to `mem_ready`.

## Configuration
- Macro `WB_ARBITER_FWD_EN`.
- Defined: adds outputs `fwd_hit1` 1, `fwd_data1` 32, `fwd_hit2` 1, `fwd_data2` 32.
  - `fwd_hitK = rf_wen && rf_rd != 0 && rf_rd == pend_rsK`.
  - `fwd_dataK = rf_wdata`.
  - These let the decode stage bypass the write landing this cycle.
- Undefined: those ports do not exist and there is no forwarding logic.
- All other behaviour is identical with or without the macro.

## Test plan
- Reset, then ALU result (rd=5, 0xDEADBEEF) → one cycle later `rf_wen=1`, `rf_rd=5`, `rf_wdata=0xDEADBEEF`; the cycle after, `rf_wen=0`.
- Same-cycle ALU (rd=3, 0x11) and mem (rd=4, 0x22) → cycle+1 writes x3; cycle+2 writes x4; `fifo_count` goes 1 then 0.
- ALU stream of 6 cycles while mem offers rd=1..5, DEPTH=4 → 4 pushes, then `mem_ready=0`. After the ALU stops, writes are x1, x2, x3, x4, then x5, in that order.
- Queue rd=7, then `pend_rs1=7` → `pend_hit=1`. Also `pend_rs2=0` with an rd=0 mem result → discarded, `pend_hit=0`, no write.
- Fill FIFO to 3 entries, assert `rst` for one cycle → `fifo_count=0` and `rf_wen=0`; no writes to the queued rds ever appear.
- With `WB_ARBITER_FWD_EN`: ALU rd=9, 0xCAFE, then `pend_rs2=9` in the write cycle → `fwd_hit2=1`, `fwd_data2=0xCAFE`; rd=0 → `fwd_hit2=0`.
